// File: rtl/async_gray_fifo.sv
// Dual-clock FIFO with Gray-coded pointers, two-flop pointer synchronizers and
// show-ahead read data. Full/empty and almost-full/almost-empty are registered.

module async_gray_fifo_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;
endmodule

module async_gray_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 2
) (
  input  logic             hbus_clk,
  input  logic             hbus_rst,
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  output logic             awfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             arempty
);
  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] AF_LVL = {1'b0, {ASIZE{1'b1}}};
  localparam logic [ASIZE:0] ONE    = {{ASIZE{1'b0}}, 1'b1};
  // A full FIFO's write Gray pointer equals the read Gray pointer with its two MSBs flipped.
  localparam logic [ASIZE:0] FMASK  = {2'b11, {(ASIZE-1){1'b0}}};

  function automatic logic [ASIZE:0] g2b(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DSIZE-1:0] mem [DEPTH];

  logic             wrst;
  logic [ASIZE:0]   wbin_q, wbin_d, wgray_q, wgray_d, wq2_rgray, wq2_rbin;
  logic             wfull_q, wfull_d, awfull_q, awfull_d, wpush;

  logic [ASIZE:0]   rbin_q, rbin_d, rgray_q, rgray_d, rq2_wgray, rq2_wbin;
  logic             rempty_q, rempty_d, arempty_q, arempty_d, rpop;

  assign wrst = ~wrst_n;

  async_gray_fifo_sync #(.W(ASIZE+1)) u_sync_r2w (
    .clk(wclk), .rst(wrst), .d(rgray_q), .q(wq2_rgray)
  );

  async_gray_fifo_sync #(.W(ASIZE+1)) u_sync_w2r (
    .clk(hbus_clk), .rst(hbus_rst), .d(wgray_q), .q(rq2_wgray)
  );

  // Write domain
  always_comb begin
    wpush    = winc & ~wfull_q;
    wbin_d   = wbin_q + (wpush ? ONE : '0);
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    wq2_rbin = g2b(wq2_rgray);
    wfull_d  = (wgray_d == (wq2_rgray ^ FMASK));
    awfull_d = wfull_d | ((wbin_d - wq2_rbin) >= AF_LVL);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      awfull_q <= awfull_d;
    end
  end

  always_ff @(posedge wclk) begin
    if (wpush) mem[wbin_q[ASIZE-1:0]] <= wdata;
  end

  // Read domain
  always_comb begin
    rpop      = rinc & ~rempty_q;
    rbin_d    = rbin_q + (rpop ? ONE : '0);
    rgray_d   = rbin_d ^ (rbin_d >> 1);
    rq2_wbin  = g2b(rq2_wgray);
    rempty_d  = (rgray_d == rq2_wgray);
    arempty_d = rempty_d | ((rq2_wbin - rbin_d) <= ONE);
  end

  always_ff @(posedge hbus_clk or posedge hbus_rst) begin
    if (hbus_rst) begin
      rbin_q    <= '0;
      rgray_q   <= '0;
      rempty_q  <= 1'b1;
      arempty_q <= 1'b1;
    end else begin
      rbin_q    <= rbin_d;
      rgray_q   <= rgray_d;
      rempty_q  <= rempty_d;
      arempty_q <= arempty_d;
    end
  end

  assign rdata   = mem[rbin_q[ASIZE-1:0]];
  assign rempty  = rempty_q;
  assign arempty = arempty_q;
  assign wfull   = wfull_q;
  assign awfull  = awfull_q;
endmodule

// File: tb/tb_async_gray_fifo.sv
// Bench for async_gray_fifo: directed flag checks plus a queue scoreboard
// whose monitor checks every accepted pop on the read side.
`timescale 1ns/1ps

module tb_async_gray_fifo;
  logic       hbus_clk, hbus_rst, wclk, wrst_n, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, awfull, rempty, arempty;

  int         npass = 0;
  int         nchk  = 0;
  logic [7:0] sbq[$];
  realtime    hhalf = 3.5;
  bit         wr_done;

  async_gray_fifo #(.DSIZE(8), .ASIZE(2)) dut (
    .hbus_clk(hbus_clk), .hbus_rst(hbus_rst), .wclk(wclk), .wrst_n(wrst_n),
    .winc(winc), .wdata(wdata), .wfull(wfull), .awfull(awfull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .arempty(arempty)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;
  initial hbus_clk = 1'b0;
  always #(hhalf) hbus_clk = ~hbus_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: inputs change just after posedge, so a pop seen at negedge is the one taken next edge.
  always @(negedge hbus_clk) begin
    if (!hbus_rst && rinc && !rempty) begin
      if (sbq.size() == 0) chk("pop_with_nothing_expected", {24'h0, rdata}, 32'hFFFF_FFFF);
      else chk("pop_data", {24'h0, rdata}, {24'h0, sbq.pop_front()});
    end
  end

  task automatic wr(input logic [7:0] d, input bit expect_accept);
    winc = 1'b1; wdata = d;
    if (expect_accept) sbq.push_back(d);
    @(posedge wclk); #1;
    winc = 1'b0;
  endtask

  task automatic pop1();
    rinc = 1'b1;
    @(posedge hbus_clk); #1;
    rinc = 1'b0;
  endtask

  task automatic writer(input int n, input bit rnd, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      while (wfull || (rnd && $urandom_range(1, 0) == 0)) begin
        winc = 1'b0;
        @(posedge wclk); #1;
        guard++;
        if (guard > 300) begin
          chk("writer_timeout", 32'd1, 32'd0);
          break;
        end
      end
      winc  = 1'b1;
      wdata = rnd ? 8'($urandom_range(255, 0)) : base + 8'(i);
      sbq.push_back(wdata);
      @(posedge wclk); #1;
    end
    winc = 1'b0;
    wr_done = 1'b1;
  endtask

  task automatic reader(input bit rnd);
    int cyc = 0;
    while (!(wr_done && sbq.size() == 0)) begin
      rinc = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      @(posedge hbus_clk); #1;
      cyc++;
      if (cyc > 5000) begin
        chk("reader_timeout", 32'd1, 32'd0);
        break;
      end
    end
    rinc = 1'b0;
  endtask

  task automatic traffic(input int n, input bit rnd, input logic [7:0] base);
    wr_done = 1'b0;
    fork
      writer(n, rnd, base);
      begin
        @(posedge hbus_clk); #1;
        reader(rnd);
      end
    join
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    int edges;
    winc = 1'b0; rinc = 1'b0; wdata = '0;
    wrst_n = 1'b0; hbus_rst = 1'b1;
    repeat (4) @(posedge wclk);
    #1;
    chk("rst_rempty", rempty, 1);
    chk("rst_arempty", arempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_awfull", awfull, 0);
    wrst_n = 1'b1; hbus_rst = 1'b0;
    @(posedge wclk); #1;

    // Fill and watch the first word reach the read side
    wr(8'h11, 1);
    edges = 0;
    while (rempty && edges < 3) begin
      @(posedge hbus_clk); #1;
      edges++;
    end
    chk("rempty_fall_within_3", rempty, 0);
    chk("show_ahead_head", rdata, 8'h11);
    wr(8'h22, 1);
    chk("awfull_after_2", awfull, 0);
    wr(8'h33, 1);
    chk("awfull_after_3", awfull, 1);
    chk("wfull_after_3", wfull, 0);
    wr(8'h44, 1);
    chk("wfull_after_4", wfull, 1);
    wr(8'h55, 0);
    chk("wfull_after_drop", wfull, 1);
    repeat (6) @(posedge hbus_clk);
    #1;
    chk("arempty_at_4", arempty, 0);

    // Drain; monitor checks the data order
    pop1();
    pop1();
    chk("arempty_at_2", arempty, 0);
    pop1();
    chk("arempty_at_1", arempty, 1);
    chk("rempty_at_1", rempty, 0);
    pop1();
    chk("rempty_after_4", rempty, 1);
    pop1();
    chk("rempty_after_extra_pop", rempty, 1);
    repeat (5) @(posedge wclk);
    #1;
    chk("wfull_after_drain", wfull, 0);
    chk("awfull_after_drain", awfull, 0);

    // Wrap-around with continuous traffic
    traffic(10, 0, 8'h00);

    // Random traffic at different clock ratio
    hhalf = 6.5;
    traffic(200, 1, 8'h00);

    // Joint reset with entries queued
    @(posedge wclk); #1;
    wr(8'hA1, 1);
    wr(8'hA2, 1);
    repeat (5) @(posedge hbus_clk);
    #1;
    chk("queued_before_reset", rempty, 0);
    wrst_n = 1'b0; hbus_rst = 1'b1;
    sbq.delete();
    repeat (3) @(posedge wclk);
    #1;
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_wfull", wfull, 0);
    chk("mid_rst_arempty", arempty, 1);
    chk("mid_rst_awfull", awfull, 0);
    wrst_n = 1'b1; hbus_rst = 1'b0;
    @(posedge wclk); #1;
    traffic(3, 0, 8'hB1);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
